seq_detect_mealy: RTL

- Parametrised Mealy sequence detector, successor to the team's fixed 2-state "consecutive ones" detector.
- Watches a serial bit stream `w` for an arbitrary LEN-bit PATTERN.
- Asserts the Mealy output `z` combinationally in the cycle the final pattern bit is present.
- Supports overlapping and non-overlapping detection, selected at run time. Sits in the FSM template library as the general-purpose serial pattern matcher.

---
 rtl/seq_detect_pkg.sv | 60 ++++++
 rtl/seq_detect_mealy.sv | 95 +++++++++
 2 files changed

// File: rtl/seq_detect_pkg.sv
// Shared helpers for the parametrised Mealy sequence detector: state width and
// elaboration-time KMP transition/failure computation.
package seq_detect_pkg;

   localparam int MAX_LEN = 16;

   typedef enum logic [1:0] {
      STEP_HOLD,
      STEP_CLEAR,
      STEP_SCAN,
      STEP_MATCH
   } step_e;

   function automatic int state_w(input int len);
      return (len <= 2) ? 1 : $clog2(len);
   endfunction

   function automatic logic bit_at(input logic [MAX_LEN:0] v, input int idx);
      logic [MAX_LEN:0] t;
      t = v >> idx;
      return t[0];
   endfunction

   // Longest proper prefix of the pattern equal to a suffix of
   // (first `state` pattern bits followed by b).
   function automatic int kmp_next(input logic [MAX_LEN-1:0] pattern, input int len,
                                   input int state, input logic b);
      logic [MAX_LEN:0] pat;
      logic [MAX_LEN:0] s;
      int best;
      logic ok;
      pat  = {1'b0, pattern};
      s    = '0;
      best = 0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < state)
            s = s | ({{MAX_LEN{1'b0}}, bit_at(pat, len - 1 - i)} << i);
      end
      s = s | ({{MAX_LEN{1'b0}}, b} << state);
      for (int l = 1; l < MAX_LEN; l++) begin
         if (l <= state + 1 && l < len) begin
            ok = 1'b1;
            for (int j = 0; j < MAX_LEN; j++) begin
               if (j < l) begin
                  if (bit_at(s, state + 1 - l + j) != bit_at(pat, len - 1 - j))
                     ok = 1'b0;
               end
            end
            if (ok)
               best = l;
         end
      end
      return best;
   endfunction

   function automatic int kmp_fail(input logic [MAX_LEN-1:0] pattern, input int len);
      return kmp_next(pattern, len, len - 1, pattern[0]);
   endfunction

endpackage

// File: rtl/seq_detect_mealy.sv
// Mealy serial pattern matcher with run-time overlap selection.
// Optional saturating match counter enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_mealy
   import seq_detect_pkg::*;
#(
   parameter int             LEN     = 4,
   parameter logic [LEN-1:0] PATTERN = 4'b1011,
   parameter int             CNT_W   = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    en,
   input  logic                    w,
   input  logic                    overlap,
   input  logic                    clear,
   output logic                    z,
   output logic [state_w(LEN)-1:0] y
`ifdef SEQ_DETECT_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0]        match_cnt
`endif
);

   localparam int                SW    = state_w(LEN);
   localparam logic [MAX_LEN-1:0] PAT16 = MAX_LEN'(PATTERN);
   localparam logic [SW-1:0]      LAST  = SW'(LEN - 1);
   localparam logic [SW-1:0]      F_LEN = SW'(kmp_fail(PAT16, LEN));

   logic [SW-1:0] s_q, s_d;
   logic [SW-1:0] nxt0 [LEN];
   logic [SW-1:0] nxt1 [LEN];
   logic          exp_tbl [LEN];
   step_e         step;

   // Transition table is fixed at elaboration; only lookups happen at run time.
   for (genvar gi = 0; gi < LEN; gi++) begin : g_tbl
      localparam int N0 = kmp_next(PAT16, LEN, gi, 1'b0);
      localparam int N1 = kmp_next(PAT16, LEN, gi, 1'b1);
      assign nxt0[gi]    = SW'(N0);
      assign nxt1[gi]    = SW'(N1);
      assign exp_tbl[gi] = PATTERN[LEN-1-gi];
   end

`ifdef SEQ_DETECT_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   assign match_cnt = cnt_q;
`endif

   always_comb begin
      step = STEP_HOLD;
      s_d  = s_q;
      z    = 1'b0;
      if (clear)
         step = STEP_CLEAR;
      else if (en)
         step = (s_q == LAST && w == exp_tbl[s_q]) ? STEP_MATCH : STEP_SCAN;

      case (step)
         STEP_CLEAR: s_d = '0;
         STEP_SCAN:  s_d = w ? nxt1[s_q] : nxt0[s_q];
         STEP_MATCH: begin
            z   = resetn;
            s_d = overlap ? F_LEN : '0;
         end
         default:    s_d = s_q;
      endcase
   end

`ifdef SEQ_DETECT_MATCH_CNT_EN
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (z && cnt_q != {CNT_W{1'b1}})
         cnt_d = cnt_q + 1'b1;
   end
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_q <= '0;
`ifdef SEQ_DETECT_MATCH_CNT_EN
         cnt_q <= '0;
`endif
      end else begin
         s_q <= s_d;
`ifdef SEQ_DETECT_MATCH_CNT_EN
         cnt_q <= cnt_d;
`endif
      end
   end

   assign y = s_q;

endmodule
